dmem_arbiter: RTL and testbench

//  Two-master round-robin arbiter sharing the single data-memory/IO port (RAM window + porta..portd regs).

---
 rtl/dmem_arb_pkg.sv | 27 ++
 rtl/rr_arb2.sv | 21 ++
 rtl/dmem_arbiter.sv | 122 ++++++++++++
 tb/tb_dmem_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM states, IO port map, RAM window defaults.
// Latency and backpressure are not applicable; the package holds no logic.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  localparam logic [31:0] PORTA_ADDR      = 32'h0000_7F00;
  localparam logic [31:0] PORTB_ADDR      = 32'h0000_7F10;
  localparam logic [31:0] PORTC_ADDR      = 32'h0000_7F20;
  localparam logic [31:0] PORTD_ADDR      = 32'h0000_7FFC;
  localparam logic [31:0] RAM_BASE_DEF    = 32'h0000_1000;
  localparam logic [31:0] RAM_BYTES_DEF   = 32'h0000_0040;
  localparam logic [31:0] DECERR_DATA_DEF = 32'hDEAD_BEEF;

  function automatic logic addr_legal(input logic [31:0] a,
                                      input logic [31:0] base,
                                      input logic [31:0] bytes);
    return ((a >= base) && (a < base + bytes)) ||
           (a == PORTA_ADDR) || (a == PORTB_ADDR) ||
           (a == PORTC_ADDR) || (a == PORTD_ADDR);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: masked requests, tie goes to the master that was not granted last.
// Purely combinational (zero latency); it applies no backpressure of its own.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic [1:0] mask,
  input  logic       last_gnt,
  output logic [1:0] gnt,
  output logic       valid
);

  logic [1:0] elig;

  always_comb begin
    elig = req & ~mask;
    gnt  = elig;
    if (elig == 2'b11) gnt = last_gnt ? 2'b01 : 2'b10;
  end

  assign valid = |elig;

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter of two masters onto the dmem/IO port; ack 2 cycles after req, one access per 2 cycles.
// Masters hold req until ack (backpressure); decode-error checking is built when DMEM_ARB_DECERR_EN is defined.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter logic [31:0] RAM_BASE    = RAM_BASE_DEF,
  parameter logic [31:0] RAM_BYTES   = RAM_BYTES_DEF,
  parameter logic [31:0] DECERR_DATA = DECERR_DATA_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_a,
  input  logic [31:0] m0_wd,
  output logic        m0_ack,
  output logic [31:0] m0_rd,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_a,
  input  logic [31:0] m1_wd,
  output logic        m1_ack,
  output logic [31:0] m1_rd,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd,
  output logic        busy,
  output logic        err
);

`ifdef DMEM_ARB_DECERR_EN
  localparam bit DECODE_EN = 1'b1;
`else
  localparam bit DECODE_EN = 1'b0;
`endif

  state_e      state;
  logic        last_gnt;
  logic        stg_id, stg_we, stg_ok;
  logic [31:0] stg_a, stg_wd;
  logic [1:0]  req, mask, gnt;
  logic        gnt_vld;
  logic        win_we, win_ok;
  logic [31:0] win_a, win_wd, rdata;

  // The master being acked still holds req during RESP, so it sits out this round.
  assign req  = {m1_req, m0_req};
  assign mask = (state == RESP) ? (stg_id ? 2'b10 : 2'b01) : 2'b00;

  rr_arb2 u_rr (
    .req      (req),
    .mask     (mask),
    .last_gnt (last_gnt),
    .gnt      (gnt),
    .valid    (gnt_vld)
  );

  assign win_we = gnt[0] ? m0_we : m1_we;
  assign win_a  = gnt[0] ? m0_a  : m1_a;
  assign win_wd = gnt[0] ? m0_wd : m1_wd;
  assign win_ok = !DECODE_EN || addr_legal(win_a, RAM_BASE, RAM_BYTES);
  assign rdata  = stg_ok ? mem_rd : DECERR_DATA;

  // Port address/data come straight from the stage registers so they hold while idle.
  assign mem_a  = stg_a;
  assign mem_wd = stg_wd;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      stg_id   <= 1'b0;
      stg_we   <= 1'b0;
      stg_ok   <= 1'b1;
      stg_a    <= '0;
      stg_wd   <= '0;
      mem_we   <= 1'b0;
      m0_ack   <= 1'b0;
      m1_ack   <= 1'b0;
      m0_rd    <= '0;
      m1_rd    <= '0;
      err      <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      err    <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (gnt_vld) begin
            state    <= ISSUE;
            last_gnt <= gnt[1];
            stg_id   <= gnt[1];
            stg_we   <= win_we;
            stg_ok   <= win_ok;
            stg_a    <= win_a;
            stg_wd   <= win_wd;
            mem_we   <= win_we && win_ok;
          end else begin
            state <= IDLE;
          end
        end
        ISSUE: begin
          // Write commits and read data is captured on this same edge.
          state <= RESP;
          err   <= DECODE_EN && !stg_ok;
          if (stg_id) begin
            m1_ack <= 1'b1;
            m1_rd  <= rdata;
          end else begin
            m0_ack <= 1'b1;
            m0_rd  <= rdata;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: emulated RAM/IO behind the port, transaction-level model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_a, m0_wd, m1_a, m1_wd;
  logic        m0_ack, m1_ack;
  logic [31:0] m0_rd, m1_rd;
  logic        mem_we, busy, err;
  logic [31:0] mem_a, mem_wd, mem_rd;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] PRESET [20] = '{
    32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003,
    32'hA000_0004, 32'hA000_0005, 32'hA000_0006, 32'hA000_0007,
    32'hA000_0008, 32'hA000_0009, 32'hA000_000A, 32'hA000_000B,
    32'hA000_000C, 32'hA000_000D, 32'hA000_000E, 32'hA000_000F,
    32'h0000_1111, 32'h0000_BEEF, 32'h0000_2222, 32'h0000_3333};

  logic [31:0] mem [20] = PRESET;
  logic [31:0] xm  [20] = PRESET;

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_a(m0_a), .m0_wd(m0_wd), .m0_ack(m0_ack), .m0_rd(m0_rd),
    .m1_req(m1_req), .m1_we(m1_we), .m1_a(m1_a), .m1_wd(m1_wd), .m1_ack(m1_ack), .m1_rd(m1_rd),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Address map of the emulated dmem_io: 0..15 RAM words, 16..19 porta..portd, -1 unmapped.
  function automatic int map(input logic [31:0] a);
    if (a >= 32'h1000 && a < 32'h1040) return int'(a[5:2]);
    case (a)
      32'h7F00: return 16;
      32'h7F10: return 17;
      32'h7F20: return 18;
      32'h7FFC: return 19;
      default:  return -1;
    endcase
  endfunction

  assign mem_rd = (map(mem_a) >= 0) ? mem[map(mem_a)] : 32'h0;

  always @(posedge clk) begin
    if (mem_we && map(mem_a) >= 0) mem[map(mem_a)] <= mem_wd;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: at most one access in flight, age 1 = on the port, age 2 = being acked.
  bit          f_vld, f_id, f_we, f_ok, last;
  int          f_age;
  logic [31:0] f_a, f_wd, e_a, e_wd, e_rd0, e_rd1;

  function automatic bit model_legal(input logic [31:0] a);
`ifdef DMEM_ARB_DECERR_EN
    return map(a) >= 0;
`else
    return (a == a);
`endif
  endfunction

  task automatic model_reset();
    f_vld = 0; f_id = 0; f_we = 0; f_ok = 1; f_age = 0; last = 1;
    f_a = 0; f_wd = 0; e_a = 0; e_wd = 0; e_rd0 = 0; e_rd1 = 0;
  endtask

  task automatic model_update();
    logic [31:0] rd;
    bit r0, r1, pick;
    if (f_vld && f_age == 1) begin
      rd = !f_ok ? 32'hDEAD_BEEF : (map(f_a) >= 0 ? xm[map(f_a)] : 32'h0);
      if (f_we && f_ok && map(f_a) >= 0) xm[map(f_a)] = f_wd;
      if (f_id) e_rd1 = rd; else e_rd0 = rd;
      f_age = 2;
    end else begin
      r0 = m0_req && !(f_vld && !f_id);
      r1 = m1_req && !(f_vld && f_id);
      if (r0 || r1) begin
        pick  = (r0 && r1) ? !last : r1;
        last  = pick;
        f_vld = 1; f_age = 1; f_id = pick;
        f_we  = pick ? m1_we : m0_we;
        f_a   = pick ? m1_a  : m0_a;
        f_wd  = pick ? m1_wd : m0_wd;
        f_ok  = model_legal(f_a);
        e_a   = f_a;
        e_wd  = f_wd;
      end else begin
        f_vld = 0;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) model_update(); else model_reset();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) model_reset();
      chk("busy",   32'(busy),   32'(f_vld));
      chk("mem_we", 32'(mem_we), 32'(f_vld && f_age == 1 && f_we && f_ok));
      chk("mem_a",  mem_a,  e_a);
      chk("mem_wd", mem_wd, e_wd);
      chk("m0_ack", 32'(m0_ack), 32'(f_vld && f_age == 2 && !f_id));
      chk("m1_ack", 32'(m1_ack), 32'(f_vld && f_age == 2 && f_id));
      chk("m0_rd",  m0_rd, e_rd0);
      chk("m1_rd",  m1_rd, e_rd1);
      chk("err",    32'(err), 32'(f_vld && f_age == 2 && !f_ok));
    end
  end

  task automatic set_req(input bit id, input bit we, input logic [31:0] a, input logic [31:0] wd);
    if (id) begin m1_req = 1; m1_we = we; m1_a = a; m1_wd = wd; end
    else    begin m0_req = 1; m0_we = we; m0_a = a; m0_wd = wd; end
  endtask

  // Holds req until ack (bounded); lat = negedges from request to ack, 0 on timeout.
  task automatic xfer(input bit id, input bit we, input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output int lat);
    set_req(id, we, a, wd);
    lat = 0;
    rd  = '0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if ((id ? m1_ack : m0_ack) === 1'b1) begin
        lat = n;
        rd  = id ? m1_rd : m0_rd;
        break;
      end
    end
    if (id) m1_req = 0; else m0_req = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 0;
    @(negedge clk);
    #2 rst_n = 1;
  endtask

  logic [31:0] rd0, rd1;
  int          lat0, lat1;
  logic [11:0] s0, s1;

  initial begin
    rst_n = 0;
    m0_req = 0; m0_we = 0; m0_a = 0; m0_wd = 0;
    m1_req = 0; m1_we = 0; m1_a = 0; m1_wd = 0;
    @(negedge clk);
    chk("rst_busy",   32'(busy),   32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_a",  mem_a,       32'h0);
    chk("rst_m0_rd",  m0_rd,       32'h0);
    chk("rst_m1_ack", 32'(m1_ack), 32'h0);
    #2 rst_n = 1;
    @(negedge clk);

    // Single write from m0.
    set_req(0, 1, 32'h1004, 32'h1234_5678);
    @(negedge clk);
    chk("wr_we_c1", 32'(mem_we), 32'h1);
    chk("wr_a_c1",  mem_a,       32'h1004);
    @(negedge clk);
    chk("wr_ack_c2",  32'(m0_ack), 32'h1);
    chk("wr_m1_ack",  32'(m1_ack), 32'h0);
    chk("wr_readback", m0_rd,      32'hA000_0001);
    chk("wr_ram1",    mem[1],      32'h1234_5678);
    m0_req = 0;
    repeat (2) @(negedge clk);

    // Both reads from reset: m0 wins the first tie, then the next idle tie also goes to m0.
    do_reset();
    fork
      xfer(0, 0, 32'h1000, 32'h0, rd0, lat0);
      xfer(1, 0, 32'h1008, 32'h0, rd1, lat1);
    join
    chk("tie1_lat0", 32'(lat0), 32'd2);
    chk("tie1_lat1", 32'(lat1), 32'd4);
    chk("tie1_rd0",  rd0, 32'hA000_0000);
    chk("tie1_rd1",  rd1, 32'hA000_0002);
    @(negedge clk);
    fork
      xfer(0, 0, 32'h1010, 32'h0, rd0, lat0);
      xfer(1, 0, 32'h1014, 32'h0, rd1, lat1);
    join
    chk("tie2_lat0", 32'(lat0), 32'd2);
    chk("tie2_lat1", 32'(lat1), 32'd4);
    chk("tie2_rd1",  rd1, 32'hA000_0005);
    repeat (2) @(negedge clk);

    // Both masters hold req continuously: acks alternate every 2 cycles.
    set_req(0, 0, 32'h1000, 32'h0);
    set_req(1, 0, 32'h100C, 32'h0);
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      s0[n] = m0_ack;
      s1[n] = m1_ack;
    end
    m0_req = 0;
    m1_req = 0;
    chk("alt_seq_m0",  32'(s0), 32'h222);
    chk("alt_seq_m1",  32'(s1), 32'h888);
    chk("alt_overlap", 32'(s0 & s1), 32'h0);
    @(negedge clk);

    // IO port read by m1 leaves m0's read data untouched.
    xfer(1, 0, 32'h7F10, 32'h0, rd1, lat1);
    chk("portb_lat", 32'(lat1), 32'd2);
    chk("portb_rd",  rd1,       32'h0000_BEEF);
    chk("portb_m0_rd_hold", m0_rd, 32'hA000_0000);
    repeat (2) @(negedge clk);

    // Reset lands during ISSUE of a write: nothing is written, outputs clear at once.
    set_req(0, 1, 32'h1008, 32'hCAFE_F00D);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("abort_busy",   32'(busy),   32'h0);
    chk("abort_mem_we", 32'(mem_we), 32'h0);
    chk("abort_mem_a",  mem_a,       32'h0);
    chk("abort_m1_rd",  m1_rd,       32'h0);
    m0_req = 0;
    repeat (2) @(negedge clk);
    chk("abort_ram2", mem[2], 32'hA000_0002);
    #2 rst_n = 1;
    @(negedge clk);

    // Write to an address outside the RAM window and IO ports.
    set_req(0, 1, 32'h2000, 32'h0000_0055);
    @(negedge clk);
`ifdef DMEM_ARB_DECERR_EN
    chk("dec_mem_we", 32'(mem_we), 32'h0);
`else
    chk("dec_mem_we", 32'(mem_we), 32'h1);
`endif
    chk("dec_mem_a", mem_a, 32'h2000);
    @(negedge clk);
    chk("dec_ack", 32'(m0_ack), 32'h1);
`ifdef DMEM_ARB_DECERR_EN
    chk("dec_rd",  m0_rd,     32'hDEAD_BEEF);
    chk("dec_err", 32'(err),  32'h1);
`else
    chk("dec_rd",  m0_rd,     32'h0);
    chk("dec_err", 32'(err),  32'h0);
`endif
    m0_req = 0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
